// File: rtl/sr_mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM for the schoolRISCV datapath, with fetch-timeout and illegal-opcode traps.
// Optional feature: define SR_MC_INSTRET_EN to add the 32-bit retired-instruction counter output instret.
module sr_mc_control #(
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemReady,
   input  logic [6:0]  cmdOp,
   input  logic [2:0]  cmdF3,
   input  logic [6:0]  cmdF7,
   input  logic        aluZero,
   output logic        imemReq,
   output logic        irWrite,
   output logic        pcWrite,
   output logic        pcSrcB,
   output logic        pcSrcJ,
   output logic        regWrite,
   output logic        aluSrc,
   output logic        wdSrc,
   output logic [2:0]  aluControl,
   output logic        halted,
   output logic [1:0]  trapCause
`ifdef SR_MC_INSTRET_EN
   ,
   output logic [31:0] instret
`endif
);

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SRL  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b100;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_FETCH   = 2'd2;

   // Counter value seen on the last FETCH cycle that may still accept imemReady.
   localparam logic [7:0] FETCH_LAST = 8'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      WB,
      TRAP
   } stateT;

   typedef enum logic [3:0] {
      I_ADD,
      I_OR,
      I_SRL,
      I_SLTU,
      I_SUB,
      I_ADDI,
      I_LUI,
      I_BEQ,
      I_BNE,
      I_JAL,
      I_ILLEGAL
   } instrT;

   function automatic instrT decodeCmd(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
      instrT kind;
      kind = I_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case ({f7, f3})
               {F7_BASE, 3'b000}: kind = I_ADD;
               {F7_BASE, 3'b110}: kind = I_OR;
               {F7_BASE, 3'b101}: kind = I_SRL;
               {F7_BASE, 3'b011}: kind = I_SLTU;
               {F7_ALT,  3'b000}: kind = I_SUB;
               default:           kind = I_ILLEGAL;
            endcase
         end
         OP_ADDI:   if (f3 == 3'b000) kind = I_ADDI;
         OP_LUI:    kind = I_LUI;
         OP_BRANCH: begin
            if (f3 == 3'b000)      kind = I_BEQ;
            else if (f3 == 3'b001) kind = I_BNE;
         end
         OP_JAL:    kind = I_JAL;
         default:   kind = I_ILLEGAL;
      endcase
      return kind;
   endfunction

   stateT      state, stateNext;
   logic [7:0] fetchCnt, fetchCntNext;
   logic [1:0] causeQ, causeNext;
   instrT      instrQ, instrNext;
   instrT      decodedKind;

   logic       ctrlAluSrc, ctrlWdSrc, ctrlRegWrite, ctrlBeq, ctrlBne, ctrlJal;
   logic [2:0] ctrlAlu;

   assign decodedKind = decodeCmd(cmdOp, cmdF3, cmdF7);

   // The decoded class is latched in DECODE so EXEC/WB controls depend on one register only.
   always_comb begin
      ctrlAluSrc   = 1'b0;
      ctrlWdSrc    = 1'b0;
      ctrlRegWrite = 1'b0;
      ctrlBeq      = 1'b0;
      ctrlBne      = 1'b0;
      ctrlJal      = 1'b0;
      ctrlAlu      = ALU_ADD;
      case (instrQ)
         I_ADD:   ctrlRegWrite = 1'b1;
         I_OR:    begin ctrlRegWrite = 1'b1; ctrlAlu = ALU_OR;   end
         I_SRL:   begin ctrlRegWrite = 1'b1; ctrlAlu = ALU_SRL;  end
         I_SLTU:  begin ctrlRegWrite = 1'b1; ctrlAlu = ALU_SLTU; end
         I_SUB:   begin ctrlRegWrite = 1'b1; ctrlAlu = ALU_SUB;  end
         I_ADDI:  begin ctrlRegWrite = 1'b1; ctrlAluSrc = 1'b1;  end
         I_LUI:   begin ctrlRegWrite = 1'b1; ctrlWdSrc = 1'b1;   end
         I_BEQ:   begin ctrlBeq = 1'b1; ctrlAlu = ALU_SUB;       end
         I_BNE:   begin ctrlBne = 1'b1; ctrlAlu = ALU_SUB;       end
         I_JAL:   begin ctrlRegWrite = 1'b1; ctrlJal = 1'b1;     end
         default: ctrlRegWrite = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         fetchCnt <= '0;
         causeQ   <= CAUSE_NONE;
         instrQ   <= I_ILLEGAL;
      end else begin
         state    <= stateNext;
         fetchCnt <= fetchCntNext;
         causeQ   <= causeNext;
         instrQ   <= instrNext;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext    = state;
      fetchCntNext = fetchCnt;
      causeNext    = causeQ;
      instrNext    = instrQ;
      imemReq      = 1'b0;
      irWrite      = 1'b0;
      pcWrite      = 1'b0;
      pcSrcB       = 1'b0;
      pcSrcJ       = 1'b0;
      regWrite     = 1'b0;
      aluSrc       = 1'b0;
      wdSrc        = 1'b0;
      aluControl   = ALU_ADD;

      case (state)
         FETCH: begin
            imemReq = 1'b1;
            if (imemReady) begin
               irWrite      = 1'b1;
               fetchCntNext = '0;
               stateNext    = DECODE;
            end else if (fetchCnt == FETCH_LAST) begin
               causeNext = CAUSE_FETCH;
               stateNext = TRAP;
            end else begin
               fetchCntNext = fetchCnt + 8'd1;
            end
         end
         DECODE: begin
            instrNext = decodedKind;
            if (decodedKind == I_ILLEGAL) begin
               causeNext = CAUSE_ILLEGAL;
               stateNext = TRAP;
            end else begin
               stateNext = EXEC;
            end
         end
         EXEC: begin
            aluSrc     = ctrlAluSrc;
            wdSrc      = ctrlWdSrc;
            aluControl = ctrlAlu;
            stateNext  = WB;
         end
         WB: begin
            aluSrc     = ctrlAluSrc;
            wdSrc      = ctrlWdSrc;
            aluControl = ctrlAlu;
            regWrite   = ctrlRegWrite;
            pcWrite    = 1'b1;
            pcSrcJ     = ctrlJal;
            pcSrcB     = (ctrlBeq & aluZero) | (ctrlBne & ~aluZero);
            stateNext  = FETCH;
         end
         TRAP:    stateNext = TRAP;
         default: stateNext = FETCH;
      endcase

      // Reset wins over the current state, so nothing may strobe while rst is high.
      if (rst) begin
         imemReq  = 1'b0;
         irWrite  = 1'b0;
         pcWrite  = 1'b0;
         pcSrcB   = 1'b0;
         pcSrcJ   = 1'b0;
         regWrite = 1'b0;
      end
   end

   assign halted    = (state == TRAP);
   assign trapCause = causeQ;

`ifdef SR_MC_INSTRET_EN
   logic [31:0] instretQ;

   // Wraps naturally at 2^32; TRAP never reaches WB, so the count freezes there.
   always_ff @(posedge clk) begin
      if (rst) begin
         instretQ <= '0;
      end else if (state == WB) begin
         instretQ <= instretQ + 32'd1;
      end
   end

   assign instret = instretQ;
`endif

endmodule
